block_matrix_sequencer: RTL and testbench

//  Initiator for the 2x2 FP32 block multiplier (start/done) and a 4-lane FP32 adder bank (stb/ack).

---
 rtl/block_matrix_sequencer_pkg.sv | 24 ++
 rtl/block_operand_mux.sv | 36 +++
 rtl/block_matrix_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_block_matrix_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_matrix_sequencer_pkg.sv
// Shared types and helpers for the 4x4 FP32 block-matrix sequencer.
// Matrices are packed row-major: element (r,c) sits at bit offset idx(r,c).
package block_matrix_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StMwait,
    StAsend,
    StAwait,
    StNext,
    StDone
  } state_e;

  localparam logic [31:0] ONE  = 32'h3f800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] FOUR = 32'h40800000;

  // Bit offset of element (r,c): 32*(4r+c).
  function automatic logic [8:0] idx(input logic [1:0] r, input logic [1:0] c);
    return {r, c, 5'b00000};
  endfunction

endpackage

// File: rtl/block_operand_mux.sv
// Selects the 2x2 operand blocks A_Ik and B_kJ for output block IJ = {blk[1], blk[0]}
// and product term k.
module block_operand_mux
  import block_matrix_sequencer_pkg::*;
(
  input  logic [511:0] i_a,
  input  logic [511:0] i_b,
  input  logic [1:0]   i_blk,
  input  logic         i_k,
  output logic [31:0]  o_a11,
  output logic [31:0]  o_a12,
  output logic [31:0]  o_a21,
  output logic [31:0]  o_a22,
  output logic [31:0]  o_b11,
  output logic [31:0]  o_b12,
  output logic [31:0]  o_b21,
  output logic [31:0]  o_b22
);

  logic w_i;
  logic w_j;

  assign w_i = i_blk[1];
  assign w_j = i_blk[0];

  assign o_a11 = i_a[idx({w_i, 1'b0}, {i_k, 1'b0}) +: 32];
  assign o_a12 = i_a[idx({w_i, 1'b0}, {i_k, 1'b1}) +: 32];
  assign o_a21 = i_a[idx({w_i, 1'b1}, {i_k, 1'b0}) +: 32];
  assign o_a22 = i_a[idx({w_i, 1'b1}, {i_k, 1'b1}) +: 32];

  assign o_b11 = i_b[idx({i_k, 1'b0}, {w_j, 1'b0}) +: 32];
  assign o_b12 = i_b[idx({i_k, 1'b0}, {w_j, 1'b1}) +: 32];
  assign o_b21 = i_b[idx({i_k, 1'b1}, {w_j, 1'b0}) +: 32];
  assign o_b22 = i_b[idx({i_k, 1'b1}, {w_j, 1'b1}) +: 32];

endmodule

// File: rtl/block_matrix_sequencer.sv
// Sequences C = A*B for 4x4 FP32 matrices over a 2x2 block multiplier (start/done)
// and a 4-lane adder bank (stb/ack); the data path is pure routing.
module block_matrix_sequencer
  import block_matrix_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MAX = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*DATA_W-1:0]  i_a,
  input  logic [16*DATA_W-1:0]  i_b,
  output logic [16*DATA_W-1:0]  o_c,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  output logic                  m_start,
  output logic [DATA_W-1:0]     m_a11,
  output logic [DATA_W-1:0]     m_a12,
  output logic [DATA_W-1:0]     m_a21,
  output logic [DATA_W-1:0]     m_a22,
  output logic [DATA_W-1:0]     m_b11,
  output logic [DATA_W-1:0]     m_b12,
  output logic [DATA_W-1:0]     m_b21,
  output logic [DATA_W-1:0]     m_b22,
  input  logic                  m_done,
  input  logic [DATA_W-1:0]     m_c11,
  input  logic [DATA_W-1:0]     m_c12,
  input  logic [DATA_W-1:0]     m_c21,
  input  logic [DATA_W-1:0]     m_c22,
  output logic [4*DATA_W-1:0]   s_add_a,
  output logic [4*DATA_W-1:0]   s_add_b,
  output logic                  s_add_stb,
  input  logic                  s_add_ack,
  input  logic [4*DATA_W-1:0]   s_add_z,
  input  logic                  s_add_z_stb,
  output logic                  s_add_z_ack
);

  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);
  // The count reaches WAIT_MAX on the edge that leaves r_wait == WAIT_MAX-1.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

  state_e                r_state;
  logic [1:0]            r_blk;
  logic                  r_k;
  logic [16*DATA_W-1:0]  r_a;
  logic [16*DATA_W-1:0]  r_b;
  logic [16*DATA_W-1:0]  r_c;
  logic [4*DATA_W-1:0]   r_p0;
  logic [4*DATA_W-1:0]   r_p1;
  logic [WaitW-1:0]      r_wait;
  logic                  r_err;
  logic                  r_done;
  logic                  r_m_start;
  logic                  r_add_stb;
  logic                  r_z_ack;
  logic [4*DATA_W-1:0]   w_prod;
  logic                  w_timeout;

  block_operand_mux u_operand_mux (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_blk (r_blk),
    .i_k   (r_k),
    .o_a11 (m_a11),
    .o_a12 (m_a12),
    .o_a21 (m_a21),
    .o_a22 (m_a22),
    .o_b11 (m_b11),
    .o_b12 (m_b12),
    .o_b21 (m_b21),
    .o_b22 (m_b22)
  );

  assign w_prod    = {m_c22, m_c21, m_c12, m_c11};
  assign w_timeout = (r_wait == WaitLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_blk     <= '0;
      r_k       <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_p0      <= '0;
      r_p1      <= '0;
      r_wait    <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_m_start <= 1'b0;
      r_add_stb <= 1'b0;
      r_z_ack   <= 1'b0;
    end else begin
      r_m_start <= 1'b0;
      r_done    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_err     <= 1'b0;
            r_blk     <= '0;
            r_k       <= 1'b0;
            r_m_start <= 1'b1;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          r_wait  <= '0;
          r_state <= StMwait;
        end
        StMwait: begin
          if (m_done) begin
            if (!r_k) begin
              r_p0      <= w_prod;
              r_k       <= 1'b1;
              r_m_start <= 1'b1;
              r_state   <= StIssue;
            end else begin
              r_p1      <= w_prod;
              r_k       <= 1'b0;
              r_wait    <= '0;
              r_add_stb <= 1'b1;
              r_state   <= StAsend;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        StAsend: begin
          if (s_add_ack) begin
            r_add_stb <= 1'b0;
            r_z_ack   <= 1'b1;
            r_wait    <= '0;
            r_state   <= StAwait;
          end else if (w_timeout) begin
            r_add_stb <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        StAwait: begin
          if (s_add_z_stb) begin
            // Lane order c11, c12, c21, c22 into block (I,J) of C.
            r_c[idx({r_blk[1], 1'b0}, {r_blk[0], 1'b0}) +: 32] <= s_add_z[31:0];
            r_c[idx({r_blk[1], 1'b0}, {r_blk[0], 1'b1}) +: 32] <= s_add_z[63:32];
            r_c[idx({r_blk[1], 1'b1}, {r_blk[0], 1'b0}) +: 32] <= s_add_z[95:64];
            r_c[idx({r_blk[1], 1'b1}, {r_blk[0], 1'b1}) +: 32] <= s_add_z[127:96];
            r_z_ack <= 1'b0;
            r_state <= StNext;
          end else if (w_timeout) begin
            r_z_ack <= 1'b0;
            r_err   <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        StNext: begin
          if (r_blk == 2'd3) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_blk     <= r_blk + 2'd1;
            r_m_start <= 1'b1;
            r_state   <= StIssue;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_c         = r_c;
  assign done        = r_done;
  assign busy        = (r_state != StIdle);
  assign err         = r_err;
  assign m_start     = r_m_start;
  assign s_add_a     = r_p0;
  assign s_add_b     = r_p1;
  assign s_add_stb   = r_add_stb;
  assign s_add_z_ack = r_z_ack;

endmodule

// File: tb/tb_block_matrix_sequencer.sv
// Directed bench for block_matrix_sequencer with behavioural block-multiplier and adder models
// working on small integer-valued FP32 operands.
module tb_block_matrix_sequencer;

  localparam logic [31:0] FP_ONE  = 32'h3f800000;
  localparam logic [31:0] FP_TWO  = 32'h40000000;
  localparam logic [31:0] FP_FOUR = 32'h40800000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] i_a, i_b, o_c;
  logic         done, busy, err, m_start, m_done;
  logic [31:0]  m_a11, m_a12, m_a21, m_a22, m_b11, m_b12, m_b21, m_b22;
  logic [31:0]  m_c11, m_c12, m_c21, m_c22;
  logic [127:0] s_add_a, s_add_b, s_add_z;
  logic         s_add_stb, s_add_ack, s_add_z_stb, s_add_z_ack;
  logic [255:0] w_ops;

  int n_tests = 0;
  int n_fail  = 0;
  int n_mstart = 0;
  int n_done   = 0;
  int stab_err = 0;
  int mul_lat;
  bit mul_hang;
  int ack_force;

  block_matrix_sequencer #(.DATA_W(32), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_a(i_a), .i_b(i_b), .o_c(o_c),
    .done(done), .busy(busy), .err(err), .m_start(m_start),
    .m_a11(m_a11), .m_a12(m_a12), .m_a21(m_a21), .m_a22(m_a22),
    .m_b11(m_b11), .m_b12(m_b12), .m_b21(m_b21), .m_b22(m_b22),
    .m_done(m_done), .m_c11(m_c11), .m_c12(m_c12), .m_c21(m_c21), .m_c22(m_c22),
    .s_add_a(s_add_a), .s_add_b(s_add_b), .s_add_stb(s_add_stb), .s_add_ack(s_add_ack),
    .s_add_z(s_add_z), .s_add_z_stb(s_add_z_stb), .s_add_z_ack(s_add_z_ack)
  );

  always #5 clk = ~clk;

  assign w_ops = {m_a11, m_a12, m_a21, m_a22, m_b11, m_b12, m_b21, m_b22};

  always @(posedge clk) begin
    if (m_start) n_mstart <= n_mstart + 1;
    if (done)    n_done   <= n_done + 1;
  end

  // Integer-valued FP32 helpers (non-negative integers below 2^24 only).
  function automatic int fp2int(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    if (e < 0 || e > 23) return -1;
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int p;
    logic [31:0] t;
    if (v <= 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 31; i++) if (v[i]) p = i;
    t = 32'(v) << (23 - p);
    return {1'b0, 8'(p + 127), t[22:0]};
  endfunction

  function automatic logic [511:0] m_fill(input logic [31:0] v);
    logic [511:0] m;
    for (int e = 0; e < 16; e++) m[32*e +: 32] = v;
    return m;
  endfunction

  function automatic logic [511:0] m_diag(input logic [31:0] v, input bit anti);
    logic [511:0] m;
    m = '0;
    for (int r = 0; r < 4; r++) m[32*(4*r + (anti ? 3 - r : r)) +: 32] = v;
    return m;
  endfunction

  // Element (r,c) = scale*(base + 4*rr + c), rr = r or 3-r when rows are reversed.
  function automatic logic [511:0] m_lin(input int base, input int scale, input bit rev);
    logic [511:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[32*(4*r + c) +: 32] = int2fp(scale * (base + 4 * (rev ? 3 - r : r) + c));
    return m;
  endfunction

  function automatic logic [511:0] ref_mul(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] m;
    int s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += fp2int(a[32*(4*r + k) +: 32]) * fp2int(b[32*(4*k + c) +: 32]);
        m[32*(4*r + c) +: 32] = int2fp(s);
      end
    return m;
  endfunction

  // Block multiplier model: responds mul_lat cycles after the m_start cycle.
  initial begin : mul_model
    int cnt;
    logic pre_ms, pre_rst;
    logic [255:0] cap;
    logic [31:0] c11, c12, c21, c22;
    cnt = 0;
    m_done = 1'b0;
    {m_c11, m_c12, m_c21, m_c22} = '0;
    forever begin
      @(posedge clk);
      pre_ms = m_start;
      pre_rst = rst_n;
      if (pre_ms) begin
        cap = w_ops;
        c11 = int2fp(fp2int(m_a11) * fp2int(m_b11) + fp2int(m_a12) * fp2int(m_b21));
        c12 = int2fp(fp2int(m_a11) * fp2int(m_b12) + fp2int(m_a12) * fp2int(m_b22));
        c21 = int2fp(fp2int(m_a21) * fp2int(m_b11) + fp2int(m_a22) * fp2int(m_b21));
        c22 = int2fp(fp2int(m_a21) * fp2int(m_b12) + fp2int(m_a22) * fp2int(m_b22));
      end
      #1;
      m_done = 1'b0;
      if (!pre_rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            m_done = 1'b1;
            {m_c11, m_c12, m_c21, m_c22} = {c11, c12, c21, c22};
            if (w_ops !== cap) stab_err++;
          end
        end
        if (pre_ms && !mul_hang) cnt = mul_lat;
      end
    end
  end

  // Adder bank model: random (or forced) ack delay, random result delay.
  initial begin : add_model
    int ack_cnt, z_cnt;
    bit z_pend;
    logic pre_stb, pre_ack, pre_zstb, pre_zack, pre_rst;
    logic [127:0] pre_a, pre_b, z_val;
    ack_cnt = -1;
    z_cnt = 0;
    z_pend = 1'b0;
    s_add_ack = 1'b0;
    s_add_z_stb = 1'b0;
    s_add_z = '0;
    forever begin
      @(posedge clk);
      pre_stb = s_add_stb; pre_ack = s_add_ack; pre_zstb = s_add_z_stb;
      pre_zack = s_add_z_ack; pre_rst = rst_n; pre_a = s_add_a; pre_b = s_add_b;
      #1;
      if (!pre_rst) begin
        ack_cnt = -1; z_pend = 1'b0; s_add_ack = 1'b0; s_add_z_stb = 1'b0;
      end else begin
        if (pre_zstb && pre_zack) s_add_z_stb = 1'b0;
        if (pre_stb && pre_ack) begin
          s_add_ack = 1'b0;
          for (int l = 0; l < 4; l++)
            z_val[32*l +: 32] = int2fp(fp2int(pre_a[32*l +: 32]) + fp2int(pre_b[32*l +: 32]));
          z_pend = 1'b1;
          z_cnt = int'($urandom_range(0, 3));
        end else if (pre_stb) begin
          if (ack_cnt < 0) ack_cnt = (ack_force > 0) ? ack_force : int'($urandom_range(0, 3));
          if (ack_cnt == 0) begin
            s_add_ack = 1'b1;
            ack_cnt = -1;
          end else begin
            ack_cnt--;
          end
        end
        if (z_pend) begin
          if (z_cnt == 0) begin
            s_add_z = z_val;
            s_add_z_stb = 1'b1;
            z_pend = 1'b0;
          end else begin
            z_cnt--;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_mstart(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (m_start) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [511:0] a, input logic [511:0] b, output bit got,
                        output int ms_cnt, output int dn_cnt, output logic err_acc);
    int ms0, dn0;
    @(negedge clk);
    ms0 = n_mstart;
    dn0 = n_done;
    i_a = a;
    i_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_acc = err;
    wait_done(got);
    repeat (3) @(negedge clk);
    ms_cnt = n_mstart - ms0;
    dn_cnt = n_done - dn0;
  endtask

  function automatic int zero_outs();
    return int'({busy, done, err, m_start, s_add_stb, s_add_z_ack});
  endfunction

  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    bit got;
    int ms_cnt, dn_cnt, dn0;
    logic err_acc;
    logic [255:0] cap_ab;
    bit hold_ok;

    rst_n = 1'b0; start = 1'b0; i_a = '0; i_b = '0;
    mul_lat = 2; mul_hang = 1'b0; ack_force = 0;
    repeat (3) @(negedge clk);
    check("reset o_c", o_c, '0);
    check_int("reset flags", zero_outs(), 0);
    check("reset mult operands", {256'd0, w_ops}, '0);
    check("reset adder operands", {256'd0, s_add_a, s_add_b}, '0);
    rst_n = 1'b1;

    vecs[0] = '{m_diag(FP_ONE, 1'b0), m_fill(FP_TWO), m_fill(FP_TWO)};
    vecs[1] = '{m_fill(FP_ONE), m_fill(FP_ONE), m_fill(FP_FOUR)};
    vecs[2] = '{m_diag(FP_ONE, 1'b0), m_lin(1, 1, 1'b0), m_lin(1, 1, 1'b0)};
    vecs[3] = '{m_lin(1, 1, 1'b0), m_diag(FP_ONE, 1'b0), m_lin(1, 1, 1'b0)};
    vecs[4] = '{m_diag(FP_TWO, 1'b0), m_lin(1, 1, 1'b0), m_lin(1, 2, 1'b0)};
    vecs[5] = '{m_diag(FP_ONE, 1'b1), m_lin(1, 1, 1'b0), m_lin(1, 1, 1'b1)};
    vecs[6] = '{m_lin(1, 1, 1'b0), m_lin(1, 1, 1'b0), ref_mul(m_lin(1, 1, 1'b0), m_lin(1, 1, 1'b0))};

    for (int v = 0; v < 7; v++) begin
      mul_lat = 1 + (v % 3);
      run_op(vecs[v].a, vecs[v].b, got, ms_cnt, dn_cnt, err_acc);
      check($sformatf("vec%0d o_c", v), o_c, vecs[v].exp);
      check_int($sformatf("vec%0d done pulses", v), dn_cnt, 1);
      check_int($sformatf("vec%0d m_start pulses", v), ms_cnt, 8);
      check_int($sformatf("vec%0d err", v), int'(err_acc), 0);
    end

    // Adder ack withheld: operands must be held with stb.
    ack_force = 5;
    @(negedge clk);
    i_a = m_fill(FP_ONE); i_b = m_fill(FP_ONE); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (s_add_stb) got = 1'b1;
      else @(negedge clk);
    end
    check_int("ack stall stb seen", int'(got), 1);
    cap_ab = {s_add_a, s_add_b};
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!s_add_stb || {s_add_a, s_add_b} !== cap_ab) hold_ok = 1'b0;
    end
    check_int("ack stall stb and payload held", int'(hold_ok), 1);
    wait_done(got);
    check_int("ack stall done", int'(got), 1);
    check("ack stall o_c", o_c, m_fill(FP_FOUR));
    ack_force = 0;

    // Multiplier never answers: timeout after WAIT_MAX cycles in MWAIT.
    mul_hang = 1'b1;
    repeat (2) @(negedge clk);
    dn0 = n_done;
    i_a = m_diag(FP_ONE, 1'b0); i_b = m_fill(FP_TWO); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mstart(got);
    check_int("timeout m_start seen", int'(got), 1);
    repeat (15) @(negedge clk);
    check_int("timeout err/busy before", int'({err, busy}), 1);
    @(negedge clk);
    check_int("timeout err/busy after", int'({err, busy}), 2);
    repeat (5) @(negedge clk);
    check_int("timeout no done", n_done - dn0, 0);
    check_int("timeout err sticky", int'(err), 1);
    check("timeout o_c kept", o_c, m_fill(FP_FOUR));
    mul_hang = 1'b0;
    run_op(m_lin(1, 1, 1'b0), m_diag(FP_ONE, 1'b0), got, ms_cnt, dn_cnt, err_acc);
    check_int("start clears err", int'(err_acc), 0);
    check("after timeout o_c", o_c, m_lin(1, 1, 1'b0));

    // Reset pulse while in MWAIT.
    mul_lat = 3;
    @(negedge clk);
    i_a = m_diag(FP_ONE, 1'b0); i_b = m_lin(1, 1, 1'b0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mstart(got);
    check_int("midreset m_start seen", int'(got), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset o_c", o_c, '0);
    check_int("midreset flags", zero_outs(), 0);
    check("midreset operands", {w_ops, s_add_a, s_add_b}, '0);
    rst_n = 1'b1;
    run_op(m_diag(FP_ONE, 1'b1), m_lin(1, 1, 1'b0), got, ms_cnt, dn_cnt, err_acc);
    check("after midreset o_c", o_c, m_lin(1, 1, 1'b1));
    check_int("after midreset m_start pulses", ms_cnt, 8);

    // Start while busy must be ignored.
    mul_lat = 2;
    @(negedge clk);
    dn0 = n_done;
    ms_cnt = n_mstart;
    i_a = m_lin(1, 1, 1'b0); i_b = m_diag(FP_ONE, 1'b0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    i_a = m_fill(FP_ONE); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(got);
    check_int("busy start done", int'(got), 1);
    check("busy start o_c", o_c, m_lin(1, 1, 1'b0));
    repeat (5) @(negedge clk);
    check_int("busy start single done", n_done - dn0, 1);
    check_int("busy start m_start pulses", n_mstart - ms_cnt, 8);
    check_int("busy start idle after", int'(busy), 0);

    check_int("mult operands stable until m_done", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
